// File: rtl/nes_pkg.sv
// nes_pkg: shared definitions for the NES controller reader and responder.
//   NES_NBITS        - button bits per controller frame
//   BTN_*            - bit position of each button in the parallel button word
//   nes_resp_state_t - responder state encoding
package nes_pkg;

  localparam int NES_NBITS = 8;

  localparam int BTN_A    = 0;
  localparam int BTN_B    = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_STRT = 3;
  localparam int BTN_U    = 4;
  localparam int BTN_D    = 5;
  localparam int BTN_L    = 6;
  localparam int BTN_R    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } nes_resp_state_t;

endpackage

// File: rtl/nes_edge_sync.sv
// nes_edge_sync: multi-stage synchronizer for an asynchronous strobe followed by
// a one-flop edge detector.
//   clk       - sampling clock
//   rst       - asynchronous, active-high reset (all flops to 0)
//   async_in  - asynchronous input level
//   level     - synchronized level
//   rise      - one-cycle strobe on a synchronized 0->1 transition
//   fall      - one-cycle strobe on a synchronized 1->0 transition
module nes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // Fewer than two stages gives no metastability protection.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Free-running: never gated by the core clock enable, so an edge seen while
  // the core is frozen is consumed here and not replayed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/nes_controller_responder.sv
// nes_controller_responder: device-side NES controller (4021-style). Latches the
// button word on the host latch strobe and shifts it out, active-low, LSB first,
// one bit per rising edge of the host shift clock.
//   CLK        - system clock
//   reset      - asynchronous, active-high reset
//   en         - clock enable for the core (synchronizers always run)
//   latch_in   - host latch strobe, asynchronous
//   pulse_in   - host shift clock, asynchronous
//   buttons    - button word, 1 = pressed
//   data_out   - serial data, 0 = pressed
//   shifting   - high while in SHIFT
//   bit_idx    - bits shifted since last latch, saturates at NBITS
//   frame_done - one-cycle pulse when the last bit has been shifted out
//
// state | meaning
// IDLE  | no frame in progress; shift clocks still push 1s through
// LOAD  | latch held: parallel load of ~buttons every cycle
// SHIFT | frame in progress; each shift clock advances one bit
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int NBITS       = NES_NBITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             latch_in,
  input  logic             pulse_in,
  input  logic [NBITS-1:0] buttons,
  output logic             data_out,
  output logic             shifting,
  output logic [3:0]       bit_idx,
  output logic             frame_done
);

  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);

  nes_resp_state_t  state;
  logic [NBITS-1:0] shreg;

  logic latch_sync, latch_fall, latch_rise_unused;
  logic pulse_rise, pulse_sync_unused, pulse_fall_unused;

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (CLK),
    .rst      (reset),
    .async_in (latch_in),
    .level    (latch_sync),
    .rise     (latch_rise_unused),
    .fall     (latch_fall)
  );

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk      (CLK),
    .rst      (reset),
    .async_in (pulse_in),
    .level    (pulse_sync_unused),
    .rise     (pulse_rise),
    .fall     (pulse_fall_unused)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '1;
      bit_idx    <= 4'd0;
      shifting   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // frame_done is a strobe and must not stretch while the core is frozen.
      frame_done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            // Latch beats a coincident shift clock.
            if (latch_sync) begin
              state <= LOAD;
            end else if (pulse_rise) begin
              shreg <= {1'b1, shreg[NBITS-1:1]};
            end
          end

          LOAD: begin
            shreg   <= ~buttons;
            bit_idx <= 4'd0;
            // Level test rather than latch_fall alone: a fall dropped while en
            // was low must not strand the FSM in LOAD.
            if (latch_fall || !latch_sync) begin
              state    <= SHIFT;
              shifting <= 1'b1;
            end
          end

          SHIFT: begin
            if (latch_sync) begin
              state    <= LOAD;
              shifting <= 1'b0;
            end else if (pulse_rise) begin
              shreg   <= {1'b1, shreg[NBITS-1:1]};
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == LAST_IDX) begin
                frame_done <= 1'b1;
                state      <= IDLE;
                shifting   <= 1'b0;
              end
            end
          end

          default: begin
            state    <= IDLE;
            shifting <= 1'b0;
          end
        endcase
      end
    end
  end

  // Bit 0 of the shift register is itself a flop, so data_out is registered
  // without adding a cycle of latency.
  assign data_out = shreg[0];

endmodule

// File: tb/tb_nes_controller_responder.sv
module tb_nes_controller_responder;
  import nes_pkg::*;

  logic       CLK;
  logic       reset;
  logic       en;
  logic       latch_in;
  logic       pulse_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       shifting;
  logic [3:0] bit_idx;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  int fd_snap;
  logic [7:0] bits;
  logic       all_ones;

  nes_controller_responder #(.NBITS(8), .SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .en         (en),
    .latch_in   (latch_in),
    .pulse_in   (pulse_in),
    .buttons    (buttons),
    .data_out   (data_out),
    .shifting   (shifting),
    .bit_idx    (bit_idx),
    .frame_done (frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_latch();
    latch_in = 1'b1;
    tick(5);
    latch_in = 1'b0;
    tick(4);
  endtask

  task automatic do_pulse();
    pulse_in = 1'b1;
    tick(4);
    pulse_in = 1'b0;
    tick(4);
  endtask

  task automatic shift_frame(output logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      b[k] = data_out;
      do_pulse();
    end
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    latch_in = 1'b0;
    pulse_in = 1'b0;
    buttons  = 8'h00;
    #1 reset = 1'b1;
    #1;
    check("rst_data_out",   {7'd0, data_out},   8'h01);
    check("rst_bit_idx",    {4'd0, bit_idx},    8'h00);
    check("rst_shifting",   {7'd0, shifting},   8'h00);
    check("rst_frame_done", {7'd0, frame_done}, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(2);

    // A pressed: first bit must appear within SYNC_STAGES+2 cycles of latch rise.
    buttons  = 8'h01;
    fd_snap  = fd_count;
    latch_in = 1'b1;
    tick(4);
    check("a_first_bit_latency", {7'd0, data_out}, 8'h00);
    tick(1);
    latch_in = 1'b0;
    tick(4);
    check("a_shifting", {7'd0, shifting}, 8'h01);
    check("a_bit_idx0", {4'd0, bit_idx},  8'h00);
    // Per-bit latency: first shift visible within SYNC_STAGES+2 cycles.
    pulse_in = 1'b1;
    tick(4);
    check("a_pulse_latency", {7'd0, data_out}, 8'h01);
    check("a_bit_idx1",      {4'd0, bit_idx},  8'h01);
    pulse_in = 1'b0;
    tick(4);
    for (int k = 1; k < 8; k++) do_pulse();
    check("a_bit_idx_end",  {4'd0, bit_idx},  8'h08);
    check("a_frame_done_n", 8'(fd_count - fd_snap), 8'h01);
    check("a_shifting_end", {7'd0, shifting}, 8'h00);
    check("a_data_idle",    {7'd0, data_out}, 8'h01);

    // 0xA5 then 9 extra pulses: bits 0,1,0,1,1,0,1,0 then ones, idx saturated.
    buttons = 8'hA5;
    do_latch();
    shift_frame(bits);
    check("a5_bits", bits, 8'h5A);
    all_ones = 1'b1;
    for (int k = 0; k < 9; k++) begin
      do_pulse();
      all_ones = all_ones & data_out;
    end
    check("a5_extra_ones", {7'd0, all_ones}, 8'h01);
    check("a5_bit_idx_sat", {4'd0, bit_idx}, 8'h08);

    // Loopback decode: UP, DN, SEL, STRT pressed.
    buttons = 8'h3C;
    do_latch();
    shift_frame(bits);
    check("loop_decoded", ~bits, 8'h3C);

    // Relatch mid-frame with new buttons: aborts without frame_done.
    buttons = 8'h01;
    do_latch();
    do_pulse();
    do_pulse();
    do_pulse();
    check("relatch_idx3", {4'd0, bit_idx}, 8'h03);
    fd_snap = fd_count;
    buttons = 8'h80;
    latch_in = 1'b1;
    tick(5);
    check("relatch_idx0",     {4'd0, bit_idx},  8'h00);
    check("relatch_in_load",  {7'd0, shifting}, 8'h00);
    latch_in = 1'b0;
    tick(4);
    check("relatch_no_fd", 8'(fd_count - fd_snap), 8'h00);
    shift_frame(bits);
    check("relatch_bits", bits, 8'h7F);
    check("relatch_fd",   8'(fd_count - fd_snap), 8'h01);

    // Latch and pulse rise together while shifting: latch wins, no shift.
    buttons = 8'h02;
    do_latch();
    do_pulse();
    check("sim_pre_idx",  {4'd0, bit_idx},  8'h01);
    check("sim_pre_data", {7'd0, data_out}, 8'h00);
    latch_in = 1'b1;
    pulse_in = 1'b1;
    tick(5);
    latch_in = 1'b0;
    pulse_in = 1'b0;
    tick(4);
    check("sim_idx",      {4'd0, bit_idx},  8'h00);
    check("sim_shifting", {7'd0, shifting}, 8'h01);
    check("sim_data",     {7'd0, data_out}, 8'h01);

    // Pulses with en low are dropped, not replayed.
    en = 1'b0;
    do_pulse();
    do_pulse();
    en = 1'b1;
    tick(3);
    check("en_idx",  {4'd0, bit_idx},  8'h00);
    check("en_data", {7'd0, data_out}, 8'h01);
    do_pulse();
    check("en_after_idx",  {4'd0, bit_idx},  8'h01);
    check("en_after_data", {7'd0, data_out}, 8'h00);

    // Async reset after 4 shifts with Up pressed (data_out low before reset).
    buttons = 8'h10;
    do_latch();
    for (int k = 0; k < 4; k++) do_pulse();
    check("mid_pre_data", {7'd0, data_out}, 8'h00);
    check("mid_pre_idx",  {4'd0, bit_idx},  8'h04);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data",     {7'd0, data_out}, 8'h01);
    check("mid_rst_idx",      {4'd0, bit_idx},  8'h00);
    check("mid_rst_shifting", {7'd0, shifting}, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(2);
    // Without a fresh latch, a shift clock leaves the idle frame untouched.
    do_pulse();
    check("post_rst_idx",  {4'd0, bit_idx},  8'h00);
    check("post_rst_data", {7'd0, data_out}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_controller_responder.md
Name: nes_controller_responder

Overview:
Device-side emulation of an NES controller, the other end of the console/reader interface. It accepts the host's latch and shift-clock strobes and presents button state on a serial data line, matching the 4021-style controller protocol. Latch and shift-clock strobes arrive asynchronous to CLK and are synchronized internally. Drives the controller port of a NES host, or loops back to our reader for self-test.

Parameters:
NBITS, 8, number of button bits shifted per frame
SYNC_STAGES, 2, flip-flop stages on each asynchronous strobe input (minimum 2)

Ports:
CLK  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  clock enable; low freezes all state except the synchronizer/edge flops
latch_in  input  1  host latch strobe, asynchronous, active-high
pulse_in  input  1  host shift clock, asynchronous, rising edge advances one bit
buttons  input  NBITS  button pressed = 1; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
data_out  output  1  serial data, active-low (pressed = 0)
shifting  output  1  high while in SHIFT state
bit_idx  output  4  number of bits shifted since the last latch, saturates at NBITS
frame_done  output  1  one-cycle pulse when the last bit has been shifted out

Behaviour:
- Reset (async): shift register all ones; data_out=1; state IDLE; bit_idx=0; shifting=0; frame_done=0; all sync/edge flops 0.
- Synchronization: latch_in and pulse_in each pass through SYNC_STAGES flops, then a one-flop edge detector producing rise/fall strobes. Edge flops update even when en=0. Edges that occur while en=0 are dropped, not queued.
- State machine with states IDLE, LOAD, SHIFT:
  - IDLE -> LOAD when latch_sync=1.
  - LOAD: shift register loads ~buttons every cycle (transparent parallel load); bit_idx=0. LOAD -> SHIFT on latch fall.
  - SHIFT: on each pulse rise, shift register shifts toward bit0, fills the MSB with 1, and bit_idx increments.
    - When bit_idx goes from NBITS-1 to NBITS: frame_done=1 for one cycle and the state returns to IDLE.
    - SHIFT -> LOAD whenever latch_sync=1, aborting the current frame without asserting frame_done.
  - IDLE: pulse rises still shift in 1s. bit_idx stays saturated at NBITS.
- data_out is always the shift register bit0, registered. After NBITS shifts it reads 1 (all released), as on an official controller.
- Latency:
  - First bit: ~buttons[0] is on data_out no later than SYNC_STAGES+2 CLK cycles after latch_in rises.
  - Each subsequent bit: valid no later than SYNC_STAGES+2 cycles after pulse_in rises.
- Simultaneous events: latch rise and pulse rise in the same cycle -> latch wins, no shift. Pulse rise while latch_sync=1 is ignored.
- Buttons are sampled only in LOAD. Changes during SHIFT do not affect the current frame.
- Host timing requirement: latch_in and pulse_in levels are held ≥ SYNC_STAGES+1 CLK cycles. Shorter glitches may be missed; this is not an error condition.
- shifting = (state == SHIFT). bit_idx is held when en=0.
- Reset asserted mid-frame returns all outputs to their reset values immediately. The next frame needs a fresh latch.

Decomposition:
- Package nes_pkg holds:
  - NES_NBITS = 8
  - button index constants BTN_A..BTN_R (0..7)
  - enum nes_resp_state_t {IDLE, LOAD, SHIFT}
  - the same package is shared with the reader side.
- Sub-module nes_edge_sync (SYNC_STAGES synchronizer plus rise/fall detector), instanced once for latch and once for pulse.

Test Plan:
- buttons=8'b0000_0001 (A pressed), latch pulse, then 8 pulses -> data_out sequence 0,1,1,1,1,1,1,1; frame_done pulses once after pulse 8; bit_idx=8.
- buttons=8'hA5, full frame with 9 extra pulses -> bits 0,1,0,1,1,0,1,0, then data_out stays 1 for the extras; bit_idx saturates at 8.
- Loopback into the existing reader: buttons=8'h3C -> reader outputs UP, DN, SEL, STRT high and all other buttons low.
- Relatch after 3 pulses with buttons changed 8'h01 -> 8'h80 -> frame restarts: no frame_done, bit_idx=0, 8th bit = 0.
- Latch rise and pulse rise in the same sync cycle -> no shift, bit_idx=0; en=0 during 2 pulses -> no shift, bit_idx unchanged after en=1.
- Assert reset after 4 shifts -> data_out=1, bit_idx=0, shifting=0 within the same cycle, with no clock edge required.
